bus_resp_collector: RTL and testbench

//  Slave-side return path of the SoC bus: takes the one-hot slave select from the

---
 rtl/bus_resp_collector.sv | 138 +++++++++++++
 tb/tb_bus_resp_collector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_resp_collector.sv
// bus_resp_collector: slave-side return path of the SoC bus.
// Gates the master strobe to the one-hot selected slave and returns that
// slave's data/ack/err to the master as a registered one-cycle response.
// Flags decode errors (select not one-hot) and slave errors.
// Optional feature macro: BUS_TIMEOUT_EN adds a hung-slave timeout.
//
// state   | meaning
// IDLE    | waiting for a master request, samples slave_sel_i
// ACTIVE  | strobe routed to selected slave, waiting for its ack/err
// DONE    | one-cycle response (m_ack_o or m_err_o high), strobes held off
module bus_resp_collector #(
  parameter int SLAVE_NUM      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            m_cyc_i,
  input  logic                            m_stb_i,
  input  logic [SLAVE_NUM-1:0]            slave_sel_i,
  output logic [SLAVE_NUM-1:0]            s_stb_o,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] s_dat_i,
  input  logic [SLAVE_NUM-1:0]            s_ack_i,
  input  logic [SLAVE_NUM-1:0]            s_err_i,
  output logic [DATA_WIDTH-1:0]           m_dat_o,
  output logic                            m_ack_o,
  output logic                            m_err_o,
  output logic                            busy_o,
  output logic [1:0]                      err_cause_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_DECODE  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_SLAVE   = 2'd3;

  logic [1:0]            state;
  logic [SLAVE_NUM-1:0]  sel_q;
  logic                  req;
  logic                  sel_onehot;
  logic                  sel_ack;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_dat;

  assign req        = m_cyc_i & m_stb_i;
  assign sel_onehot = (slave_sel_i != '0) &&
                      ((slave_sel_i & (slave_sel_i - 1'b1)) == '0);
  assign sel_ack    = |(s_ack_i & sel_q);
  assign sel_err    = |(s_err_i & sel_q);
  assign busy_o     = (state == ST_ACTIVE);
  assign s_stb_o    = (state == ST_ACTIVE) ? (sel_q & {SLAVE_NUM{req}}) : '0;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYCLES[TIMEOUT_W-1:0];
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt_nxt;
  logic                 tmo_hit;
  // tmo_cnt_nxt counts the current ACTIVE cycle, so the hit lands on the last allowed one
  assign tmo_cnt_nxt = tmo_cnt + 1'b1;
  assign tmo_hit     = (tmo_cnt_nxt == TMO_LAST);
`endif

  // Read-data mux driven by the latched one-hot select
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      if (sel_q[k]) sel_dat = sel_dat | s_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Transfer sequencing and registered master response
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      m_dat_o     <= '0;
      m_ack_o     <= 1'b0;
      m_err_o     <= 1'b0;
      err_cause_o <= CAUSE_NONE;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (sel_onehot) begin
              sel_q       <= slave_sel_i;
              err_cause_o <= CAUSE_NONE;
              state       <= ST_ACTIVE;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end else begin
              m_err_o     <= 1'b1;
              err_cause_o <= CAUSE_DECODE;
              state       <= ST_DONE;
            end
          end
        end
        ST_ACTIVE: begin
`ifdef BUS_TIMEOUT_EN
          tmo_cnt <= tmo_cnt_nxt;
`endif
          if (sel_err) begin
            m_err_o     <= 1'b1;
            m_dat_o     <= '0;
            err_cause_o <= CAUSE_SLAVE;
            state       <= ST_DONE;
          end else if (sel_ack) begin
            m_ack_o <= 1'b1;
            m_dat_o <= sel_dat;
            state   <= ST_DONE;
          end else if (!m_cyc_i) begin
            state <= ST_IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_hit) begin
            m_err_o     <= 1'b1;
            err_cause_o <= CAUSE_TIMEOUT;
            state       <= ST_DONE;
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_resp_collector.sv
// tb_bus_resp_collector: transaction-scripted bench for bus_resp_collector.
// Each transfer is scheduled cycle by cycle; the schedule itself states what
// every output must be in each cycle, and a negedge process compares them.
module tb_bus_resp_collector;
  localparam int SN = 3;
  localparam int DW = 32;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO  = 4;
  localparam int MAXW = 2;
`else
  localparam int TMO  = 255;
  localparam int MAXW = 4;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              m_cyc_i, m_stb_i;
  logic [SN-1:0]     slave_sel_i;
  logic [SN-1:0]     s_stb_o;
  logic [SN*DW-1:0]  s_dat_i;
  logic [SN-1:0]     s_ack_i, s_err_i;
  logic [DW-1:0]     m_dat_o;
  logic              m_ack_o, m_err_o, busy_o;
  logic [1:0]        err_cause_o;

  logic [SN-1:0]     exp_stb;
  logic [DW-1:0]     exp_dat;
  logic              exp_ack, exp_err, exp_busy;
  logic [1:0]        exp_cause;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bus_resp_collector #(
    .SLAVE_NUM(SN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .slave_sel_i(slave_sel_i), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .busy_o(busy_o),
    .err_cause_o(err_cause_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the scheduled expectations
  always @(negedge clk) begin
    if (check_en) begin
      chk("s_stb", 64'(s_stb_o), 64'(exp_stb));
      chk("m_dat", 64'(m_dat_o), 64'(exp_dat));
      chk("m_ack", 64'(m_ack_o), 64'(exp_ack));
      chk("m_err", 64'(m_err_o), 64'(exp_err));
      chk("busy", 64'(busy_o), 64'(exp_busy));
      chk("err_cause", 64'(err_cause_o), 64'(exp_cause));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    s_ack_i = 3'($urandom);
    s_err_i = 3'($urandom);
    s_dat_i = {$urandom, $urandom, $urandom};
  endtask

  task automatic quiet_exp();
    exp_ack = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_stb = '0;
  endtask

  task automatic idle();
    next_cycle();
    m_cyc_i = 1'b0; m_stb_i = 1'($urandom); slave_sel_i = 3'($urandom); noise();
    quiet_exp();
  endtask

  // kind: 0 ack, 1 slave err, 2 master abort, 3 no response (timeout), 4 err+ack with other slaves acking
  task automatic xfer(input logic [SN-1:0] sel, input int kind, input int waits,
                      input logic [DW-1:0] data);
    int idx;
    idx = 0;
    for (int k = 0; k < SN; k++) if (sel[k]) idx = k;
    next_cycle();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; slave_sel_i = sel; noise();
    quiet_exp();
    if ($countones(sel) != 1) begin
      next_cycle();
      m_cyc_i = 1'($urandom); m_stb_i = 1'($urandom); slave_sel_i = 3'($urandom); noise();
      quiet_exp();
      exp_err = 1'b1; exp_cause = 2'd1;
      return;
    end
    for (int j = 0; j <= waits; j++) begin
      next_cycle();
      quiet_exp();
      exp_busy = 1'b1; exp_cause = 2'd0;
      m_cyc_i = 1'b1;
      m_stb_i = (j == waits) ? 1'b1 : 1'($urandom);
      slave_sel_i = 3'($urandom);
      noise();
      s_ack_i = s_ack_i & ~sel;
      s_err_i = s_err_i & ~sel;
      if (kind == 4) s_ack_i = ~sel;
      if (j == waits) begin
        case (kind)
          0: begin s_ack_i = s_ack_i | sel; s_dat_i[idx*DW +: DW] = data; end
          1: s_err_i = s_err_i | sel;
          2: begin m_cyc_i = 1'b0; m_stb_i = 1'($urandom); end
          4: begin s_err_i = s_err_i | sel; s_ack_i = s_ack_i | sel; end
          default: ;
        endcase
      end
      exp_stb = (m_cyc_i && m_stb_i) ? sel : '0;
    end
    next_cycle();
    m_cyc_i = 1'($urandom); m_stb_i = 1'($urandom); slave_sel_i = 3'($urandom); noise();
    quiet_exp();
    case (kind)
      0: begin exp_ack = 1'b1; exp_dat = data; end
      1, 4: begin exp_err = 1'b1; exp_dat = '0; exp_cause = 2'd3; end
      2: m_cyc_i = 1'b0;
      3: begin exp_err = 1'b1; exp_cause = 2'd2; end
      default: ;
    endcase
  endtask

  initial begin
    int kind, waits;
    logic [SN-1:0] sel;
    reset = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; slave_sel_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0;
    quiet_exp(); exp_dat = '0; exp_cause = 2'd0;
    next_cycle();
    check_en = 1'b1;
    next_cycle();
    chk("reset_dat", 64'(m_dat_o), 64'h0);
    next_cycle();
    reset = 1'b0;
    idle();

    // Slave 1 acks after 2 wait cycles
    xfer(3'b010, 0, 2, 32'hDEADBEEF);
    chk("t1_ack", 64'(m_ack_o), 64'h1);
    chk("t1_dat", 64'(m_dat_o), 64'hDEADBEEF);
    chk("t1_cause", 64'(err_cause_o), 64'h0);
    idle();

    // Decode errors: no select and two selects
    xfer(3'b000, 0, 0, 32'h0);
    chk("t2a_err", 64'(m_err_o), 64'h1);
    chk("t2a_cause", 64'(err_cause_o), 64'h1);
    idle();
    xfer(3'b011, 0, 0, 32'h0);
    chk("t2b_err", 64'(m_err_o), 64'h1);
    chk("t2b_cause", 64'(err_cause_o), 64'h1);
    idle();

    // Slave 0 ack+err together, other slaves acking
    xfer(3'b001, 4, 1, 32'h0);
    chk("t3_err", 64'(m_err_o), 64'h1);
    chk("t3_ack", 64'(m_ack_o), 64'h0);
    chk("t3_cause", 64'(err_cause_o), 64'h3);
    chk("t3_dat", 64'(m_dat_o), 64'h0);
    idle();

`ifdef BUS_TIMEOUT_EN
    xfer(3'b100, 3, TMO - 1, 32'h0);
    chk("t4_err", 64'(m_err_o), 64'h1);
    chk("t4_cause", 64'(err_cause_o), 64'h2);
`else
    xfer(3'b100, 0, 1000, 32'h0BADF00D);
    chk("t4_ack", 64'(m_ack_o), 64'h1);
    chk("t4_dat", 64'(m_dat_o), 64'h0BADF00D);
`endif
    idle();

    // Master abort, then reset in the middle of a transfer
    xfer(3'b100, 2, 1, 32'h0);
    chk("t5_busy", 64'(busy_o), 64'h0);
    chk("t5_ack", 64'(m_ack_o), 64'h0);
    next_cycle();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; slave_sel_i = 3'b010; s_ack_i = '0; s_err_i = '0;
    quiet_exp();
    next_cycle();
    reset = 1'b1; s_ack_i = 3'b101;
    exp_busy = 1'b1; exp_stb = 3'b010; exp_cause = 2'd0;
    next_cycle();
    reset = 1'b0; m_cyc_i = 1'b0;
    quiet_exp(); exp_dat = '0; exp_cause = 2'd0;
    chk("t5_rst_dat", 64'(m_dat_o), 64'h0);
    chk("t5_rst_busy", 64'(busy_o), 64'h0);
    idle();

    // Back-to-back zero-wait reads
    xfer(3'b001, 0, 0, 32'h11112222);
    chk("t6a_dat", 64'(m_dat_o), 64'h11112222);
    xfer(3'b100, 0, 0, 32'h33334444);
    chk("t6b_ack", 64'(m_ack_o), 64'h1);
    chk("t6b_dat", 64'(m_dat_o), 64'h33334444);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) != 0) sel = 3'b001 << $urandom_range(0, 2);
      else sel = 3'($urandom);
      case ($urandom_range(0, 3))
        0: kind = 0;
        1: kind = 1;
        2: kind = 2;
        default: kind = 4;
      endcase
      if ($urandom_range(0, 1) == 1) kind = 0;
      waits = $urandom_range(0, MAXW);
      xfer(sel, kind, waits, $urandom);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    idle();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
